// File: rtl/tx_serialiser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_pkg
// Purpose  : Shared types and helpers for the photonic lane transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package tx_pkg;

  // Serialiser FSM: waiting for a packet, or driving beats onto the lane.
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // Integer ceiling division, used to size the beat count of a burst.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_serialiser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo
// Purpose  : Synchronous packet FIFO, power-of-two depth, with occupancy
//            level. Pushes while full and pops while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointer and level next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  // Storage array; contents need no reset since level gates all reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and level registers; reset discards every stored packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : tx_serialiser
// Purpose  : Frames {dest_id, data, src_id} packets, buffers them, and
//            serialises each onto a LANE_W-bit optical lane as a burst of
//            beats, most-significant beat first, with sof/eof markers.
// Revision : 1.0 - initial release
// ============================================================================
module tx_serialiser
  import tx_pkg::*;
#(
  parameter int ID_W   = 2,
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ID_W-1:0]        dest_id_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [ID_W-1:0]        src_id_i,
  output logic                   link_valid_o,
  input  logic                   link_ready_i,
  output logic [LANE_W-1:0]      link_data_o,
  output logic                   link_sof_o,
  output logic                   link_eof_o,
  output logic [$clog2(DEPTH):0] fifo_level_o
);

  localparam int PKT_W   = 2 * ID_W + DATA_W;
  localparam int BEATS   = ceil_div(PKT_W, LANE_W);
  localparam int SHIFT_W = BEATS * LANE_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0]   fifo_rdata;

  // in_ready depends only on the registered level, never on link_ready.
  assign in_ready_o = !fifo_full;
  assign fifo_push  = in_valid_i && !fifo_full;

  tx_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({dest_id_i, data_i, src_id_i}),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state: load a packet when idle, advance a beat on each accepted
  // transfer, and chain straight into the next packet after the last beat.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shreg_d    = shreg_q;
    fifo_pop   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = SHIFT_W'(fifo_rdata);
          beat_cnt_d = '0;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        if (link_ready_i) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = SHIFT_W'(fifo_rdata);
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            shreg_d    = shreg_q << LANE_W;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State, beat counter and shift register; reset abandons any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      beat_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Lane outputs are decoded purely from registered state.
  assign link_valid_o = (state_q == TX_SEND);
  assign link_data_o  = shreg_q[SHIFT_W-1 -: LANE_W];
  assign link_sof_o   = link_valid_o && (beat_cnt_q == '0);
  assign link_eof_o   = link_valid_o && (beat_cnt_q == LAST_BEAT);

endmodule
`default_nettype wire

// File: tb/tb_tx_serialiser.sv
`timescale 1ns/1ps
module tb_tx_serialiser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [1:0] dest;
  logic [7:0] data;
  logic [1:0] src;
  logic       link_ready;
  logic       aux_ready;

  logic       in_ready, link_valid, sof, eof;
  logic [3:0] link_data;
  logic [2:0] level;

  logic       in_ready5, link_valid5, sof5, eof5;
  logic [4:0] link_data5;
  logic [2:0] level5;

  logic        in_ready12, link_valid12, sof12, eof12;
  logic [11:0] link_data12;
  logic [2:0]  level12;

  tx_serialiser dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .dest_id_i(dest), .data_i(data), .src_id_i(src),
    .link_valid_o(link_valid), .link_ready_i(link_ready), .link_data_o(link_data),
    .link_sof_o(sof), .link_eof_o(eof), .fifo_level_o(level)
  );

  tx_serialiser #(.LANE_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready5),
    .dest_id_i(dest), .data_i(data), .src_id_i(src),
    .link_valid_o(link_valid5), .link_ready_i(aux_ready), .link_data_o(link_data5),
    .link_sof_o(sof5), .link_eof_o(eof5), .fifo_level_o(level5)
  );

  tx_serialiser #(.LANE_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready12),
    .dest_id_i(dest), .data_i(data), .src_id_i(src),
    .link_valid_o(link_valid12), .link_ready_i(aux_ready), .link_data_o(link_data12),
    .link_sof_o(sof12), .link_eof_o(eof12), .fifo_level_o(level12)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted packet becomes three expected beats for the
  // default 4-bit lane, MS beat first, delivered in push order.
  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       e;
  } beat_t;
  beat_t exp_q[$];

  always @(posedge clk) begin : model_update
    logic [11:0] w;
    beat_t       bt;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (link_valid && link_ready && exp_q.size() > 0) exp_q.delete(0);
      if (in_valid && in_ready) begin
        w = {dest, data, src};
        for (int k = 0; k < 3; k++) begin
          bt.d = w[(2 - k) * 4 +: 4];
          bt.s = (k == 0);
          bt.e = (k == 2);
          exp_q.push_back(bt);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (rst_n) begin
      chk("in_ready_rule", 32'(in_ready), 32'(level != 3'd4));
      if (link_valid) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("sb_data", 32'(link_data), 32'(exp_q[0].d));
          chk("sb_sof", 32'(sof), 32'(exp_q[0].s));
          chk("sb_eof", 32'(eof), 32'(exp_q[0].e));
        end
      end else begin
        chk("idle_markers", 32'({sof, eof}), 32'd0);
      end
    end
  end

  task automatic wait_valid(input int max);
    int n = 0;
    while (!link_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(link_valid), 32'd1);
  endtask

  task automatic offer(input logic [1:0] d, input logic [7:0] p, input logic [1:0] s);
    in_valid = 1'b1;
    dest = d;
    data = p;
    src = s;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; dest = '0; data = '0; src = '0;
    link_ready = 1'b1; aux_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(link_valid), 32'd0);
    chk("rst_sof_eof", 32'({sof, eof}), 32'd0);
    chk("rst_data", 32'(link_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet, word 12'h696, on all three lane widths
    offer(2'b01, 8'hA5, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_not_yet_valid", 32'(link_valid), 32'd0);
    @(negedge clk);
    chk("t1_b0_valid", 32'(link_valid), 32'd1);
    chk("t1_b0_data", 32'(link_data), 32'h6);
    chk("t1_b0_sof", 32'(sof), 32'd1);
    chk("t1_b0_eof", 32'(eof), 32'd0);
    chk("t1_level_after_pop", 32'(level), 32'd0);
    chk("l5_b0_data", 32'(link_data5), 32'h01);
    chk("l5_b0_sof", 32'(sof5), 32'd1);
    chk("l12_data", 32'(link_data12), 32'h696);
    chk("l12_sof_eof", 32'({sof12, eof12}), 32'h3);
    @(negedge clk);
    chk("t1_b1_data", 32'(link_data), 32'h9);
    chk("t1_b1_markers", 32'({sof, eof}), 32'd0);
    chk("l5_b1_data", 32'(link_data5), 32'h14);
    chk("l12_done", 32'(link_valid12), 32'd0);
    @(negedge clk);
    chk("t1_b2_data", 32'(link_data), 32'h6);
    chk("t1_b2_eof", 32'(eof), 32'd1);
    chk("l5_b2_data", 32'(link_data5), 32'h16);
    chk("l5_b2_eof", 32'(eof5), 32'd1);
    @(negedge clk);
    chk("t1_valid_drop", 32'(link_valid), 32'd0);
    chk("l5_valid_drop", 32'(link_valid5), 32'd0);

    // Backpressure on beat 1
    offer(2'b01, 8'hA5, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(8);
    chk("t2_b0_data", 32'(link_data), 32'h6);
    @(negedge clk);
    chk("t2_b1_data", 32'(link_data), 32'h9);
    link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_data", 32'(link_data), 32'h9);
      chk("t2_stall_valid", 32'(link_valid), 32'd1);
    end
    link_ready = 1'b1;
    @(negedge clk);
    chk("t2_b2_data", 32'(link_data), 32'h6);
    chk("t2_b2_eof", 32'(eof), 32'd1);
    @(negedge clk);
    chk("t2_valid_drop", 32'(link_valid), 32'd0);

    // Fill: 5 pushes with the lane stalled, 6th refused, then drain
    link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(2'(i), 8'h30 + 8'(i), 2'(3 - i));
      @(negedge clk);
    end
    chk("t3_level_full", 32'(level), 32'd4);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    offer(2'b11, 8'hEE, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("t3_refused_level", 32'(level), 32'd4);
    chk("t3_refused_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    link_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("t3_drain_valid", 32'(link_valid), 32'd1);
      chk("t3_drain_sof", 32'(sof), 32'(i % 3 == 0));
      chk("t3_drain_eof", 32'(eof), 32'(i % 3 == 2));
      @(negedge clk);
    end
    chk("t3_drain_end", 32'(link_valid), 32'd0);
    chk("t3_drain_level", 32'(level), 32'd0);

    // Reset mid-packet with two packets queued
    link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(2'(i), 8'hC0 + 8'(i), 2'b01);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4_queued", 32'(level), 32'd2);
    link_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    link_ready = 1'b0;
    chk("t4_on_beat2", 32'(eof), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(link_valid), 32'd0);
    chk("t4_rst_level", 32'(level), 32'd0);
    chk("t4_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t4_rst_markers", 32'({sof, eof}), 32'd0);
    chk("t4_rst_data", 32'(link_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    link_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_quiet_valid", 32'(link_valid), 32'd0);
    chk("t4_quiet_level", 32'(level), 32'd0);
    offer(2'b11, 8'h5A, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(8);
    chk("t4_new_sof", 32'(sof), 32'd1);
    chk("t4_new_data", 32'(link_data), 32'hD);
    repeat (4) @(negedge clk);
    chk("t4_new_done", 32'(link_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
